// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the single-cycle MIPS datapath: accepts one
// instruction at a time, decodes it into a latched IR and sequences phase controls.
module datapath_controller #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] Instructions,
  input  logic        Zero,
  output logic        RegDst,
  output logic        RegWr,
  output logic        ALUsrc,
  output logic [1:0]  ALUcntrl,
  output logic        MemWr,
  output logic        MemToReg,
  output logic        Branch,
  output logic        Jump,
  output logic        branch_taken,
  output logic        illegal
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_BAD
  } kind_t;

  state_t        state, next_state;
  kind_t         kind;
  logic [5:0]    ir_op;
  logic [5:0]    ir_funct;
  logic [CW-1:0] mem_cnt;
  logic          armed;
  logic          accept;
  logic          unused_bits;

  // Only opcode and funct steer control; the register/immediate fields go straight to the datapath.
  assign unused_bits = ^Instructions[25:6];
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    kind = K_BAD;
    case (ir_op)
      6'b000000: begin
        case (ir_funct)
          6'b100000: kind = K_ADD;
          6'b100010: kind = K_SUB;
          6'b100100: kind = K_AND;
          6'b100101: kind = K_OR;
          default:   kind = K_BAD;
        endcase
      end
      6'b001000: kind = K_ADDI;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b000010: kind = K_J;
      default:   kind = K_BAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // armed holds instr_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_op    <= '0;
      ir_funct <= '0;
      mem_cnt  <= '0;
      illegal  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        ir_op    <= Instructions[31:26];
        ir_funct <= Instructions[5:0];
      end
      if (state == EXEC && next_state == MEM)
        mem_cnt <= CW'(MEM_WAIT - 1);
      else if (state == MEM && mem_cnt != '0)
        mem_cnt <= mem_cnt - 1'b1;
      if (state == DECODE && kind == K_BAD)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    RegDst      = 1'b0;
    RegWr       = 1'b0;
    ALUsrc      = 1'b0;
    ALUcntrl    = 2'b00;
    MemWr       = 1'b0;
    MemToReg    = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;

    case (state)
      IDLE: begin
        instr_ready = armed;
        if (instr_valid && armed) next_state = DECODE;
      end
      DECODE: begin
        next_state = (kind == K_BAD) ? IDLE : EXEC;
      end
      EXEC: begin
        case (kind)
          K_LW, K_SW:  next_state = MEM;
          K_BEQ, K_J:  next_state = IDLE;
          default:     next_state = WB;
        endcase
        Branch = (kind == K_BEQ);
        Jump   = (kind == K_J);
      end
      MEM: begin
        if (mem_cnt == '0) begin
          next_state = (kind == K_LW) ? WB : IDLE;
          MemWr      = (kind == K_SW);
        end
      end
      WB: begin
        RegWr      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // Level controls hold for the whole instruction and are zero while idle.
    if (state != IDLE) begin
      case (kind)
        K_ADD:  RegDst = 1'b1;
        K_SUB:  begin RegDst = 1'b1; ALUcntrl = 2'b01; end
        K_AND:  begin RegDst = 1'b1; ALUcntrl = 2'b10; end
        K_OR:   begin RegDst = 1'b1; ALUcntrl = 2'b11; end
        K_ADDI: ALUsrc = 1'b1;
        K_SW:   ALUsrc = 1'b1;
        K_LW:   begin ALUsrc = 1'b1; MemToReg = 1'b1; end
        K_BEQ:  ALUcntrl = 2'b01;
        default: ;
      endcase
    end
  end

  assign branch_taken = Branch & Zero;

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench for datapath_controller: per-cycle expected control vectors are
// queued when an instruction is driven and compared as the controller steps through it.
module tb_datapath_controller;

  localparam int MW = 3;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instructions;
  logic        Zero;
  logic        RegDst, RegWr, ALUsrc, MemWr, MemToReg, Branch, Jump, branch_taken, illegal;
  logic [1:0]  ALUcntrl;

  int total = 0;
  int bad   = 0;
  logic [11:0] expq[$];
  logic ill_model = 1'b0;

  datapath_controller #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instructions(Instructions), .Zero(Zero), .RegDst(RegDst), .RegWr(RegWr),
    .ALUsrc(ALUsrc), .ALUcntrl(ALUcntrl), .MemWr(MemWr), .MemToReg(MemToReg),
    .Branch(Branch), .Jump(Jump), .branch_taken(branch_taken), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic rdy, ill, rd, wr, src,
                                       input logic [1:0] alu,
                                       input logic mw, m2r, br, jmp, tk);
    return {rdy, ill, rd, wr, src, alu, mw, m2r, br, jmp, tk};
  endfunction

  function automatic logic [11:0] observed();
    return pack(instr_ready, illegal, RegDst, RegWr, ALUsrc, ALUcntrl,
                MemWr, MemToReg, Branch, Jump, branch_taken);
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%b want=%b (rdy ill rd wr src alu mw m2r br j tk)", tag, got, exp);
    end
  endtask

  // Reference model: expected vector for the accepting idle cycle and every phase after it.
  task automatic buildExpect(input logic [31:0] instr, input logic z);
    logic [5:0] op, fn;
    logic rt, addi, lw, sw, beq, jj, rd, src, m2r;
    logic [1:0] alu;
    op = instr[31:26];
    fn = instr[5:0];
    rt   = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25);
    addi = (op == 6'h08);
    lw   = (op == 6'h23);
    sw   = (op == 6'h2B);
    beq  = (op == 6'h04);
    jj   = (op == 6'h02);
    rd = rt; src = addi | lw | sw; m2r = lw; alu = 2'b00;
    if (rt) alu = (fn == 6'h20) ? 2'b00 : (fn == 6'h22) ? 2'b01 : (fn == 6'h24) ? 2'b10 : 2'b11;
    if (beq) alu = 2'b01;
    expq.push_back(pack(1, ill_model, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    if (!(rt | addi | lw | sw | beq | jj)) begin
      expq.push_back(pack(0, ill_model, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      ill_model = 1'b1;
      return;
    end
    expq.push_back(pack(0, ill_model, rd, 0, src, alu, 0, m2r, 0, 0, 0));
    expq.push_back(pack(0, ill_model, rd, 0, src, alu, 0, m2r, beq, jj, beq & z));
    if (lw | sw)
      for (int k = 0; k < MW; k++)
        expq.push_back(pack(0, ill_model, rd, 0, src, alu, sw && (k == MW - 1), m2r, 0, 0, 0));
    if (!(beq | jj | sw))
      expq.push_back(pack(0, ill_model, rd, 1, src, alu, 0, m2r, 0, 0, 0));
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic z);
    int waitc;
    logic first;
    waitc = 0;
    while (!instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!instr_ready) begin
      checkOutput({tag, "_ready_timeout"}, observed(),
                  pack(1, ill_model, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      return;
    end
    buildExpect(instr, z);
    Instructions = instr;
    Zero         = z;
    instr_valid  = 1'b1;
    first        = 1'b1;
    #1;
    while (expq.size() > 0) begin
      if (!first) @(negedge clk);
      checkOutput(tag, observed(), expq.pop_front());
      if (!first) begin
        instr_valid  = 1'b0;
        Instructions = $urandom;
      end
      first = 1'b0;
    end
    @(negedge clk);
    instr_valid  = 1'b0;
    Instructions = $urandom;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; Instructions = '0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("por", observed(), 12'b0);
    reset = 1'b0;
    #1 checkOutput("por_release", observed(), 12'b0);
    @(negedge clk);
    checkOutput("por_ready", observed(), pack(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));

    applyStimulus("addi", 32'h200107DF, 1'b0);
    applyStimulus("add",  32'h00220820, 1'b0);
    applyStimulus("sub",  32'h00221822, 1'b1);
    applyStimulus("and",  32'h00221824, 1'b0);
    applyStimulus("or",   32'h00221825, 1'b0);
    applyStimulus("sw",   32'hAC020000, 1'b0);
    applyStimulus("lw",   32'h8C030000, 1'b0);
    applyStimulus("beq_z1", 32'h10220004, 1'b1);
    applyStimulus("beq_z0", 32'h10220004, 1'b0);
    applyStimulus("j",    32'h08000010, 1'b1);
    applyStimulus("ill_op", 32'hFC000000, 1'b0);
    applyStimulus("ill_fn", 32'h0000003F, 1'b0);
    applyStimulus("addi_after_ill", 32'h200107DF, 1'b0);
    applyStimulus("idle_check", 32'h00221825, 1'b0);

    // Abort a store mid-MEM with an asynchronous reset.
    Instructions = 32'hAC020000; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("rst_async", observed(), 12'b0);
    ill_model = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold", observed(), 12'b0);
    end
    reset = 1'b0;
    #1 checkOutput("rst_release", observed(), 12'b0);
    @(negedge clk);
    checkOutput("rst_ready", observed(), pack(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    applyStimulus("addi_after_rst", 32'h200107DF, 1'b0);
    applyStimulus("lw_after_rst",   32'h8C030000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
